// File: rtl/ysyx_210247_wb_stage_pkg.sv
// ysyx_210247_wb_stage_pkg
// Shared widths and MEM->WB bus field offsets. The MEM stage packs the bus
// with the same offsets, so both sides stay consistent from one place.
//   REG_BUS        : integer register / data width
//   DST_BUS        : register-file index width
//   MEM_TO_WB_BUS  : total MEM->WB bus width
//   WB_*_LSB       : least significant bit of each bus field
package ysyx_210247_wb_stage_pkg;

    localparam int REG_BUS       = 64;
    localparam int DST_BUS       = 5;
    localparam int CSR_ADDR_W    = 12;
    localparam int INST_W        = 32;
    localparam int EXC_OP_W      = 32;
    localparam int MEM_TO_WB_BUS = 403;

    localparam int WB_WDATA_LSB     = 0;
    localparam int WB_WDEST_LSB     = 64;
    localparam int WB_WEN_LSB       = 69;
    localparam int WB_INST_LSB      = 70;
    localparam int WB_PC_LSB        = 102;
    localparam int WB_CSR_WDATA_LSB = 166;
    localparam int WB_CSR_WADDR_LSB = 230;
    localparam int WB_CSR_WEN_LSB   = 242;
    localparam int WB_EXC_OP_LSB    = 243;
    localparam int WB_EXC_ADDR_LSB  = 275;
    localparam int WB_EXC_TYPE_LSB  = 339;

    // Any non-zero exception type marks the instruction as trapping.
    function automatic logic exc_pending(input logic [REG_BUS-1:0] exc_type);
        return |exc_type;
    endfunction

endpackage

// File: rtl/ysyx_210247_wb_stage_if.sv
// ysyx_210247_wb_stage_if
// MEM->WB valid/allow handshake plus the packed MEM->WB bus.
//   wb_valid_in     : MEM holds a valid instruction
//   wb_allow_in     : WB can accept this cycle
//   mem_to_wb_bus_i : packed instruction payload
// master = MEM stage side, slave = WB stage side.
interface ysyx_210247_wb_stage_if;
    import ysyx_210247_wb_stage_pkg::*;

    logic                     wb_valid_in;
    logic                     wb_allow_in;
    logic [MEM_TO_WB_BUS-1:0] mem_to_wb_bus_i;

    modport master (
        output wb_valid_in,
        output mem_to_wb_bus_i,
        input  wb_allow_in
    );

    modport slave (
        input  wb_valid_in,
        input  mem_to_wb_bus_i,
        output wb_allow_in
    );
endinterface

// File: rtl/ysyx_210247_wb_stage.sv
// ysyx_210247_wb_stage
// Write-back stage: latches the MEM->WB bus, drives the register-file and CSR
// write ports and the forwarding path, resolves traps (flush + redirect) and
// counts normally retired instructions.
//   clock, reset       : clock and asynchronous active-high reset
//   mem_wb             : MEM->WB handshake and bus (slave side)
//   rf_*               : integer register-file write port
//   csr_*_o            : CSR write port
//   WB_wdest/WB_result : forwarding path (WB_wdest = 0 when nothing to forward)
//   trap_*_o           : trap report for the CSR unit
//   flush_o/redirect_pc_o : pipeline kill and new fetch pc
//   commit_*, instret  : difftest commit info and retired-instruction count
module ysyx_210247_wb_stage
    import ysyx_210247_wb_stage_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    ysyx_210247_wb_stage_if.slave     mem_wb,
    output logic                      rf_wen,
    output logic [DST_BUS-1:0]        rf_waddr,
    output logic [REG_BUS-1:0]        rf_wdata,
    output logic                      csr_wen_o,
    output logic [CSR_ADDR_W-1:0]     csr_waddr_o,
    output logic [REG_BUS-1:0]        csr_wdata_o,
    output logic [DST_BUS-1:0]        WB_wdest,
    output logic [REG_BUS-1:0]        WB_result,
    output logic                      trap_o,
    output logic [REG_BUS-1:0]        trap_cause_o,
    output logic [REG_BUS-1:0]        trap_pc_o,
    output logic                      flush_o,
    output logic [REG_BUS-1:0]        redirect_pc_o,
    output logic                      commit_valid,
    output logic [REG_BUS-1:0]        commit_pc,
    output logic [INST_W-1:0]         commit_inst,
    output logic [REG_BUS-1:0]        instret
);

    logic                     wb_valid_q, wb_valid_d;
    logic [MEM_TO_WB_BUS-1:0] wb_bus_q,   wb_bus_d;
    logic [REG_BUS-1:0]       instret_q,  instret_d;

    // Kept as a real signal so a multi-cycle write-back can stall here later.
    logic wb_ready_go;
    logic wb_allow;
    logic accept;
    logic is_trap;
    logic retire;

    // Bus fields
    logic [REG_BUS-1:0]    f_exc_type, f_exc_addr, f_csr_wdata, f_pc, f_wdata;
    logic [CSR_ADDR_W-1:0] f_csr_waddr;
    logic [INST_W-1:0]     f_inst;
    logic [DST_BUS-1:0]    f_wdest;
    logic                  f_csr_wen, f_wen;
    // exc_op is held for the future trap-return decode but not used yet.
    logic [EXC_OP_W-1:0]   unused_exc_op;

    assign f_wdata       = wb_bus_q[WB_WDATA_LSB     +: REG_BUS];
    assign f_wdest       = wb_bus_q[WB_WDEST_LSB     +: DST_BUS];
    assign f_wen         = wb_bus_q[WB_WEN_LSB];
    assign f_inst        = wb_bus_q[WB_INST_LSB      +: INST_W];
    assign f_pc          = wb_bus_q[WB_PC_LSB        +: REG_BUS];
    assign f_csr_wdata   = wb_bus_q[WB_CSR_WDATA_LSB +: REG_BUS];
    assign f_csr_waddr   = wb_bus_q[WB_CSR_WADDR_LSB +: CSR_ADDR_W];
    assign f_csr_wen     = wb_bus_q[WB_CSR_WEN_LSB];
    assign unused_exc_op = wb_bus_q[WB_EXC_OP_LSB    +: EXC_OP_W];
    assign f_exc_addr    = wb_bus_q[WB_EXC_ADDR_LSB  +: REG_BUS];
    assign f_exc_type    = wb_bus_q[WB_EXC_TYPE_LSB  +: REG_BUS];

    assign wb_ready_go        = 1'b1;
    assign wb_allow           = !wb_valid_q || wb_ready_go;
    assign mem_wb.wb_allow_in = wb_allow;

    // flush_o depends only on registered state, so gating the accept with it
    // creates no combinational loop back to the MEM bus.
    assign is_trap = wb_valid_q && exc_pending(f_exc_type);
    assign retire  = wb_valid_q && !is_trap;
    assign accept  = mem_wb.wb_valid_in && wb_allow && !flush_o;

    assign rf_wen      = retire && f_wen && (f_wdest != '0);
    assign rf_waddr    = f_wdest;
    assign rf_wdata    = f_wdata;
    assign csr_wen_o   = retire && f_csr_wen;
    assign csr_waddr_o = f_csr_waddr;
    assign csr_wdata_o = f_csr_wdata;

    assign WB_wdest  = f_wdest & {DST_BUS{retire && f_wen}};
    assign WB_result = f_wdata;

    assign trap_o        = is_trap;
    assign trap_cause_o  = f_exc_type;
    assign trap_pc_o     = f_pc;
    assign flush_o       = is_trap;
    assign redirect_pc_o = f_exc_addr;

    assign commit_valid = retire;
    assign commit_pc    = f_pc;
    assign commit_inst  = f_inst;
    assign instret      = instret_q;

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_bus_d   = wb_bus_q;
        instret_d  = instret_q;
        // Instructions younger than a trap are dropped during the flush cycle.
        if (wb_allow) begin
            wb_valid_d = mem_wb.wb_valid_in && !flush_o;
        end
        if (accept) begin
            wb_bus_d = mem_wb.mem_to_wb_bus_i;
        end
        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_bus_q   <= '0;
            instret_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_bus_q   <= wb_bus_d;
            instret_q  <= instret_d;
        end
    end

endmodule

// File: tb/tb_ysyx_210247_wb_stage.sv
module tb_ysyx_210247_wb_stage;
    import ysyx_210247_wb_stage_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_210247_wb_stage_if mem_wb ();

    logic                  rf_wen;
    logic [4:0]            rf_waddr;
    logic [63:0]           rf_wdata;
    logic                  csr_wen_o;
    logic [11:0]           csr_waddr_o;
    logic [63:0]           csr_wdata_o;
    logic [4:0]            WB_wdest;
    logic [63:0]           WB_result;
    logic                  trap_o;
    logic [63:0]           trap_cause_o;
    logic [63:0]           trap_pc_o;
    logic                  flush_o;
    logic [63:0]           redirect_pc_o;
    logic                  commit_valid;
    logic [63:0]           commit_pc;
    logic [31:0]           commit_inst;
    logic [63:0]           instret;

    ysyx_210247_wb_stage dut (
        .clock         (clock),
        .reset         (reset),
        .mem_wb        (mem_wb.slave),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .csr_wen_o     (csr_wen_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .WB_wdest      (WB_wdest),
        .WB_result     (WB_result),
        .trap_o        (trap_o),
        .trap_cause_o  (trap_cause_o),
        .trap_pc_o     (trap_pc_o),
        .flush_o       (flush_o),
        .redirect_pc_o (redirect_pc_o),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_inst   (commit_inst),
        .instret       (instret)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Field order: exc_type, exc_addr, exc_op, csr_wen, csr_waddr, csr_wdata,
    // pc, inst, wen, wdest, wdata.
    function automatic logic [402:0] mk_bus(
        input logic [63:0] exc_type, input logic [63:0] exc_addr,
        input logic        csr_wen,  input logic [11:0] csr_waddr,
        input logic [63:0] csr_wdata, input logic [63:0] pc,
        input logic [31:0] inst, input logic wen, input logic [4:0] wdest,
        input logic [63:0] wdata);
        return {exc_type, exc_addr, 32'h0, csr_wen, csr_waddr, csr_wdata,
                pc, inst, wen, wdest, wdata};
    endfunction

    // Present one instruction for one cycle (call at a negedge).
    task automatic drive(input logic [402:0] bus);
        mem_wb.wb_valid_in     = 1'b1;
        mem_wb.mem_to_wb_bus_i = bus;
        $display("[TB] drive pc=0x%0h exc=0x%0h", bus[165:102], bus[402:339]);
    endtask

    task automatic idle();
        mem_wb.wb_valid_in     = 1'b0;
        mem_wb.mem_to_wb_bus_i = '0;
    endtask

    initial begin
        logic       exp_csr;
        int         commits;
        idle();
        // ---- reset state ----
        repeat (2) @(negedge clock);
        check("rst_allow",   {63'd0, mem_wb.wb_allow_in}, 64'd1);
        check("rst_commit",  {63'd0, commit_valid}, 64'd0);
        check("rst_instret", instret, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // ---- basic retire ----
        drive(mk_bus(64'd0, 64'd0, 1'b0, 12'd0, 64'd0, 64'h80000000,
                     32'h00000293, 1'b1, 5'd5, 64'h1234));
        @(negedge clock);
        idle();
        check("basic_rf_wen",  {63'd0, rf_wen}, 64'd1);
        check("basic_waddr",   {59'd0, rf_waddr}, 64'd5);
        check("basic_wdata",   rf_wdata, 64'h1234);
        check("basic_commit",  {63'd0, commit_valid}, 64'd1);
        check("basic_fwd",     {59'd0, WB_wdest}, 64'd5);
        check("basic_fwd_res", WB_result, 64'h1234);
        check("basic_pc",      commit_pc, 64'h80000000);
        check("basic_inst",    {32'd0, commit_inst}, 64'h00000293);
        check("basic_trap",    {63'd0, trap_o}, 64'd0);
        check("basic_inst0",   instret, 64'd0);
        @(negedge clock);
        check("basic_inst1",   instret, 64'd1);
        check("basic_empty_commit", {63'd0, commit_valid}, 64'd0);
        check("basic_empty_fwd",    {59'd0, WB_wdest}, 64'd0);

        // ---- wen=1, wdest=0 ----
        drive(mk_bus(64'd0, 64'd0, 1'b0, 12'd0, 64'd0, 64'h80000004,
                     32'h00000013, 1'b1, 5'd0, 64'h55));
        @(negedge clock);
        idle();
        check("x0_rf_wen", {63'd0, rf_wen}, 64'd0);
        check("x0_fwd",    {59'd0, WB_wdest}, 64'd0);
        check("x0_commit", {63'd0, commit_valid}, 64'd1);
        @(negedge clock);
        check("x0_instret", instret, 64'd2);

        // ---- trap followed by a younger instruction ----
        drive(mk_bus(64'd11, 64'h80001000, 1'b1, 12'h300, 64'h9, 64'h80000008,
                     32'h00000073, 1'b1, 5'd7, 64'h77));
        @(negedge clock);
        drive(mk_bus(64'd0, 64'd0, 1'b0, 12'd0, 64'd0, 64'h8000000c,
                     32'h00100493, 1'b1, 5'd9, 64'h99));
        check("trap_o",       {63'd0, trap_o}, 64'd1);
        check("trap_flush",   {63'd0, flush_o}, 64'd1);
        check("trap_redir",   redirect_pc_o, 64'h80001000);
        check("trap_cause",   trap_cause_o, 64'd11);
        check("trap_pc",      trap_pc_o, 64'h80000008);
        check("trap_rf_wen",  {63'd0, rf_wen}, 64'd0);
        check("trap_csr_wen", {63'd0, csr_wen_o}, 64'd0);
        check("trap_commit",  {63'd0, commit_valid}, 64'd0);
        check("trap_fwd",     {59'd0, WB_wdest}, 64'd0);
        @(negedge clock);
        idle();
        check("young_commit", {63'd0, commit_valid}, 64'd0);
        check("young_rf_wen", {63'd0, rf_wen}, 64'd0);
        check("young_flush",  {63'd0, flush_o}, 64'd0);
        check("young_trap",   {63'd0, trap_o}, 64'd0);
        check("trap_instret", instret, 64'd2);
        @(negedge clock);
        check("young_commit2", {63'd0, commit_valid}, 64'd0);
        check("trap_instret2", instret, 64'd2);

        // ---- asynchronous reset mid-stream ----
        drive(mk_bus(64'd0, 64'd0, 1'b1, 12'h300, 64'h1, 64'h80000010,
                     32'h30001073, 1'b1, 5'd3, 64'hab));
        @(posedge clock);
        #2;
        idle();
        reset = 1'b1;
        @(negedge clock);
        check("mrst_allow",   {63'd0, mem_wb.wb_allow_in}, 64'd1);
        check("mrst_rf_wen",  {63'd0, rf_wen}, 64'd0);
        check("mrst_csr_wen", {63'd0, csr_wen_o}, 64'd0);
        check("mrst_commit",  {63'd0, commit_valid}, 64'd0);
        check("mrst_fwd",     {59'd0, WB_wdest}, 64'd0);
        check("mrst_wdata",   rf_wdata, 64'd0);
        check("mrst_pc",      commit_pc, 64'd0);
        check("mrst_flush",   {63'd0, flush_o}, 64'd0);
        check("mrst_instret", instret, 64'd0);
        reset = 1'b0;

        // ---- ten back-to-back, every third one writes CSR 0x300 ----
        commits = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                exp_csr = ((i - 1) % 3) == 0;
                if (commit_valid) commits++;
                check($sformatf("b2b_commit%0d", i - 1), {63'd0, commit_valid}, 64'd1);
                check($sformatf("b2b_csr%0d", i - 1), {63'd0, csr_wen_o}, {63'd0, exp_csr});
                check($sformatf("b2b_pc%0d", i - 1), commit_pc, 64'h80000100 + 64'(4 * (i - 1)));
                if (exp_csr)
                    check($sformatf("b2b_caddr%0d", i - 1), {52'd0, csr_waddr_o}, 64'h300);
            end
            if (i < 10)
                drive(mk_bus(64'd0, 64'd0, (i % 3) == 0, 12'h300, 64'(i), 64'h80000100 + 64'(4 * i),
                             32'h13, 1'b1, 5'(i + 1), 64'(i * 17)));
            else
                idle();
            @(negedge clock);
        end
        check("b2b_count",   64'(commits), 64'd10);
        check("b2b_instret", instret, 64'd10);

        // ---- instret wrap ----
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(mk_bus(64'd0, 64'd0, 1'b0, 12'd0, 64'd0, 64'h80000200,
                     32'h13, 1'b1, 5'd1, 64'h1));
        @(negedge clock);
        idle();
        check("wrap_commit", {63'd0, commit_valid}, 64'd1);
        @(negedge clock);
        check("wrap_instret", instret, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_210247_wb_stage.md
# ysyx_210247_wb_stage

Write-back stage of the five-stage in-order core. It accepts the MEM→WB bus under the valid/allow handshake and holds it in a pipeline register. From that register it drives the integer register-file write port, the CSR write port, and the register forwarding path. It also resolves traps by flushing the pipeline and redirecting fetch, and it maintains the retired-instruction counter with difftest commit outputs.

## Interface
Parameters:
- none; widths come from `REG_BUS` (64), `DST_BUS` (5) and `MEM_TO_WB_BUS` (403) in defines.v.

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- wb_valid_in  in  1  MEM stage holds a valid instruction (mem_valid_out)
- wb_allow_in  out  1  WB can accept this cycle
- mem_to_wb_bus_i  in  403  {exc_type[402:339], exc_addr[338:275], exc_op[274:243], csr_wen[242], csr_waddr[241:230], csr_wdata[229:166], pc[165:102], inst[101:70], wen[69], wdest[68:64], wdata[63:0]}
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  destination register
- rf_wdata  out  64  write data
- csr_wen_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR address
- csr_wdata_o  out  64  CSR write data
- WB_wdest  out  5  forwarding destination, 0 when WB is empty
- WB_result  out  64  forwarding data
- trap_o  out  1  trap retiring this cycle
- trap_cause_o  out  64  exc_type of the trapping instruction
- trap_pc_o  out  64  pc of the trapping instruction
- flush_o  out  1  kill IF/ID/EXE/MEM contents
- redirect_pc_o  out  64  new fetch pc (exc_addr)
- commit_valid  out  1  instruction retires normally this cycle
- commit_pc  out  64  pc of the retiring instruction
- commit_inst  out  32  instruction word of the retiring instruction
- instret  out  64  count of normally retired instructions

## Operation
- Pipeline register (`wb_bus`, `wb_valid`): loads `mem_to_wb_bus_i` on each edge where `wb_valid_in && wb_allow_in && !flush_o`.
- `wb_valid` update on each edge:
  - If `wb_allow_in`: `wb_valid` takes `wb_valid_in && !flush_o`.
  - Otherwise `wb_valid` holds.
- `wb_ready_go` is 1, so `wb_allow_in = !wb_valid || wb_ready_go` is always 1 out of reset. The handshake is still implemented in full so a future multi-cycle write-back can clear `wb_ready_go`.
- `is_trap = wb_valid && (exc_type != 0)`.
- Normal retire (`wb_valid && !is_trap`):
  - `rf_wen = wen && (wdest != 0)`, with `rf_waddr = wdest` and `rf_wdata = wdata`.
  - `csr_wen_o = csr_wen`, with CSR address and data passed through.
  - `commit_valid = 1`.
  - `instret` increments by 1 at the next edge (64-bit, wraps from 2^64-1 to 0).
- Trap retire (`is_trap`):
  - `rf_wen`, `csr_wen_o` and `commit_valid` are forced to 0; `instret` does not increment.
  - `trap_o = 1`, `trap_cause_o = exc_type`, `trap_pc_o = pc`.
  - `flush_o = 1`, `redirect_pc_o = exc_addr`.
  - The CSR unit uses `trap_*` to update mepc/mcause.
- Forwarding:
  - `WB_wdest = wdest & {5{wb_valid && wen && !is_trap}}`.
  - `WB_result = wdata`.
- `exc_op` is latched but not driven out. It is reserved for the trap-return decode extension.

## Timing
- Reset (asynchronous, on any cycle, including mid-trap):
  - `wb_valid = 0`, `wb_bus = 0`, `instret = 0`.
  - Every output is 0 except `wb_allow_in = 1`.
- Latency: an instruction accepted at edge N drives rf/csr/commit/trap outputs combinationally during cycle N+1. The register file writes at edge N+1.
- `flush_o` is one cycle wide per trapping instruction and comes from registered state only; there is no combinational path from `mem_to_wb_bus_i` to `flush_o`.
- During a flush cycle, MEM's instruction is younger than the trap. It is discarded: `wb_valid` is 0 at the next edge, with no commit and no write.
- Back-to-back instructions: one retires per cycle with no bubble.
- A valid instruction may carry `wdest = 0` with `wen = 1`: `rf_wen = 0`, `commit_valid = 1`, and `WB_wdest = 0`.

## Structure
- Bus field offsets (`WB_EXC_TYPE_LSB`, …, `WB_WDATA_LSB`) and `MEM_TO_WB_BUS` belong in defines.v, shared with the MEM stage.
- Single module, no sub-modules.
- `instret` is a plain counter inside this module; it is not a separate block.

## Test plan
- Reset mid-stream with `wb_valid = 1` -> the next cycle shows all outputs 0, `instret = 0`, `wb_allow_in = 1`.
- Present pc=0x80000000, wen=1, wdest=5, wdata=0x1234, exc_type=0 for one cycle -> next cycle `rf_wen = 1`, `rf_waddr = 5`, `rf_wdata = 0x1234`, `commit_valid = 1`, `WB_wdest = 5`, `commit_pc = 0x80000000`; `instret` goes 0→1.
- wen=1, wdest=0 -> `rf_wen = 0`, `WB_wdest = 0`, `commit_valid = 1`, `instret` increments.
- exc_type=11, exc_addr=0x80001000, followed by a valid younger instruction -> `flush_o = 1`, `redirect_pc_o = 0x80001000`, `trap_cause_o = 11`, `rf_wen = 0`; the younger instruction never commits; `instret` unchanged.
- Ten back-to-back valid instructions, some with csr_wen=1 (csr_waddr=0x300) -> ten consecutive `commit_valid` cycles; `csr_wen_o` high exactly on the CSR instructions; `instret = 10`.
- Preload `instret = 2^64-1` by forcing the register, then retire one instruction -> `instret = 0`.
